// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler for two byte requesters sharing one 8N1 UART TX line.
// Drives the external baud divider enable and aligns frames to its rising edges.
`timescale 1ns/1ps
module uart_tx_scheduler #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 ClkIn,
   input  logic                 Reset,
   input  logic                 Valid0,
   input  logic [DATA_BITS-1:0] Data0,
   output logic                 Ack0,
   input  logic                 Valid1,
   input  logic [DATA_BITS-1:0] Data1,
   output logic                 Ack1,
   input  logic                 BaudClk,
   output logic                 BaudEn,
   output logic                 TxOut,
   output logic                 Busy,
   output logic                 GrantId
);

   localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 ptr_q, ptr_d;
   logic                 tx_q, tx_d;
   logic                 baud_en_q, baud_en_d;
   logic                 busy_q, busy_d;
   logic                 grant_id_q, grant_id_d;
   logic                 ack0_q, ack0_d;
   logic                 ack1_q, ack1_d;
   logic                 prev_q, prev_d;

   logic tick, stop_done, arb_pt, grant, winner;

   assign tick      = BaudClk & ~prev_q;
   assign stop_done = (state_q == STOP) & tick & (bitcnt_q == LAST_STOP);
   assign arb_pt    = (state_q == IDLE) | stop_done;
   assign grant     = arb_pt & (Valid0 | Valid1);
   // With both requesters valid the pointer decides; otherwise the lone requester wins.
   assign winner    = (Valid0 & Valid1) ? ptr_q : Valid1;

   always_ff @(posedge ClkIn) begin
      if (Reset) begin
         state_q    <= IDLE;
         bitcnt_q   <= '0;
         ptr_q      <= 1'b0;
         tx_q       <= 1'b1;
         baud_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         grant_id_q <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         prev_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         ptr_q      <= ptr_d;
         tx_q       <= tx_d;
         baud_en_q  <= baud_en_d;
         busy_q     <= busy_d;
         grant_id_q <= grant_id_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         prev_q     <= prev_d;
      end
   end

   always_ff @(posedge ClkIn) begin
      shreg_q <= shreg_d;
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      case (state_q)
         IDLE:  if (grant) state_d = ARM;
         ARM:   if (tick) state_d = START;
         START: begin
            if (tick) begin
               state_d  = DATA;
               bitcnt_d = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bitcnt_q == LAST_DATA) begin
                  state_d  = STOP;
                  bitcnt_d = '0;
               end else begin
                  bitcnt_d = bitcnt_q + CNT_W'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (bitcnt_q == LAST_STOP) begin
                  state_d  = grant ? START : IDLE;
                  bitcnt_d = '0;
               end else begin
                  bitcnt_d = bitcnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_d       = tx_q;
      baud_en_d  = baud_en_q;
      busy_d     = busy_q;
      grant_id_d = grant_id_q;
      ptr_d      = ptr_q;
      shreg_d    = shreg_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      prev_d     = baud_en_q & BaudClk;
      if (grant) begin
         ack0_d     = ~winner;
         ack1_d     = winner;
         grant_id_d = winner;
         ptr_d      = ~winner;
         shreg_d    = winner ? Data1 : Data0;
      end
      case (state_q)
         IDLE: begin
            tx_d      = 1'b1;
            baud_en_d = grant;
            busy_d    = grant;
         end
         ARM: if (tick) tx_d = 1'b0;
         START: begin
            if (tick) begin
               tx_d    = shreg_q[0];
               shreg_d = shreg_q >> 1;
            end
         end
         DATA: begin
            if (tick) begin
               if (bitcnt_q == LAST_DATA) begin
                  tx_d = 1'b1;
               end else begin
                  tx_d    = shreg_q[0];
                  shreg_d = shreg_q >> 1;
               end
            end
         end
         STOP: begin
            // A grant on the last stop tick starts the next frame with no idle gap.
            if (stop_done) begin
               if (grant) begin
                  tx_d = 1'b0;
               end else begin
                  baud_en_d = 1'b0;
                  busy_d    = 1'b0;
               end
            end
         end
         default: tx_d = 1'b1;
      endcase
   end

   assign Ack0    = ack0_q;
   assign Ack1    = ack1_q;
   assign BaudEn  = baud_en_q;
   assign TxOut   = tx_q;
   assign Busy    = busy_q;
   assign GrantId = grant_id_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmit line between two byte requesters (requester 0 is the hash-result reporter; requester 1 is the status/echo path).
- Uses round-robin arbitration and serialises 8N1 frames.
- Sequences the 9600-baud clock divider by driving its enable: the divider is enabled only while frames are in flight.
- Sits between the hasher control logic and the TX pin, alongside the baud divider instance.

Parameters:
- DATA_BITS, 8, data bits per frame (LSB first)
- STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
- ClkIn  input  1  system clock (50 MHz)
- Reset  input  1  synchronous, active-high reset
- Valid0  input  1  requester 0 has a byte; held with Data0 until Ack0
- Data0  input  DATA_BITS  requester 0 byte
- Ack0  output  1  one-cycle pulse: Data0 latched
- Valid1  input  1  requester 1 has a byte; held with Data1 until Ack1
- Data1  input  DATA_BITS  requester 1 byte
- Ack1  output  1  one-cycle pulse: Data1 latched
- BaudClk  input  1  divider output; it is 0 while disabled and toggles every MAX_CNT+1 cycles while enabled
- BaudEn  output  1  divider enable
- TxOut  output  1  serial line, idle high
- Busy  output  1  high from grant until the frame ends with no back-to-back grant
- GrantId  output  1  source of the frame in flight

Behaviour:
- Reset values (next edge with Reset=1): TxOut=1, BaudEn=0, Ack0=Ack1=0, Busy=0, GrantId=0, state IDLE, bit counter 0, RR pointer favours requester 0, edge-detect register 0.
- Baud tick: rise = BaudClk & ~prev_q. prev_q is registered every cycle and forced to 0 while BaudEn=0.
- All outputs are registered.
- Arbitration:
  - Happens only in IDLE, or on the tick ending the last stop bit.
  - Only one requester valid: it wins.
  - Both valid: the pointer side wins.
  - After any grant, the pointer moves to the other requester.
  - On grant, the winner's Ack pulses one cycle, its data is latched, and GrantId is updated.
- States:
  - IDLE: TxOut=1, BaudEn=0, Busy=0. Any Valid in cycle n gives Ack, Busy=1, BaudEn=1 in cycle n+1. Next state is ARM.
  - ARM: TxOut=1, waiting for the first tick, so the start bit aligns to divider phase. Tick goes to START with TxOut=0.
  - START: the start bit. Tick goes to DATA, TxOut=data[0], bitcnt=0.
  - DATA: each tick increments bitcnt and drives TxOut=data[bitcnt]. The tick after bit DATA_BITS-1 goes to STOP with TxOut=1.
  - STOP: counts STOP_BITS ticks. On the final tick:
    - A Valid is present: grant as above and go directly to START with TxOut=0 on that same registered update. BaudEn stays 1 (gapless back-to-back).
    - Otherwise: go to IDLE, BaudEn=0, Busy=0.
- Bit period = 2·(MAX_CNT+1) ClkIn cycles. Frame = (1+DATA_BITS+STOP_BITS) bit periods, measured from the START tick.
- Valid/Data are sampled only at arbitration points. Changes in mid-frame are ignored. A Valid dropped before Ack is never granted.
- Reset mid-frame: the frame is aborted and TxOut returns to 1 on the next edge. No Ack is re-issued and the latched byte is discarded.
- A tick arriving in IDLE is impossible (BaudEn=0) and is ignored.

Test Plan (divider MAX_CNT=1 ⇒ tick every 4 cycles, bit period 4 cycles):
1. Reset, then Valid0=1, Data0=0xA5 -> Ack0 one cycle later, BaudEn=1; TxOut stays 1 until the first tick, then shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop), each held 4 cycles. Then BaudEn=0, Busy=0.
2. Both Valid from IDLE (Data0=0x11, Data1=0x22) -> frame 0x11 with GrantId=0, then Ack1 on the final stop tick and 0x22 starts with no idle gap. BaudEn stays high throughout.
3. Requester 1 continuously valid with requester 0 pulsing -> grants alternate 1/0/1. No requester wins twice while the other is waiting.
4. Reset asserted mid-DATA -> next cycle TxOut=1, BaudEn=0, Busy=0. After release, a new Valid1=0x3C produces a clean full frame.
5. Data0 changed mid-frame from 0x5A to 0xFF -> the transmitted bits remain 0x5A.
6. STOP_BITS=2, Data1=0x00 -> line low for 9 bit periods and high for 2 bit periods before IDLE.
